// File: rtl/imem_load_ctrl.sv
// Arbitrates instruction-memory ownership between normal fetch and the debug loader:
// freeze and drain fetch, stream debug words into memory, then restart fetch at PC 0.
module imem_load_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             core_stall,
  input  logic [1:0]       core_pcsel,
  input  logic             dbg_req,
  input  logic             dbg_valid,
  input  logic             dbg_last,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_instr,
  output logic             dbg_ready,
  output logic             fe_stall,
  output logic [1:0]       fe_pcsel,
  output logic             mem_we,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic [CNT_W-1:0] load_count,
  output logic             addr_err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_LAST_I);
  localparam logic [ADDR_W-1:0] DEPTH      = ADDR_W'(MEM_DEPTH);
  localparam logic [1:0]        PCSEL_ZERO = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_RESTART
  } state_e;

  state_e              state_q, state_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]    load_count_q, load_count_d;
  logic                addr_err_q, addr_err_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;
  logic                in_range;

  // Next-state, counters and frontend/memory drive
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    load_count_d = load_count_q;
    addr_err_d   = addr_err_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    accept       = 1'b0;
    in_range     = (dbg_addr < DEPTH);
    fe_stall     = core_stall;
    fe_pcsel     = core_pcsel;
    dbg_ready    = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = waddr_q;
    mem_wdata    = wdata_q;

    unique case (state_q)
      ST_RUN: begin
        if (dbg_req) begin
          drain_cnt_d  = '0;
          load_count_d = '0;
          addr_err_d   = 1'b0;
          state_d      = (DRAIN_CYCLES == 0) ? ST_LOAD : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        fe_stall = 1'b1;
        if (!dbg_req) begin
          state_d = ST_RESTART;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_LOAD;
        end else begin
          drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        end
      end

      ST_LOAD: begin
        fe_stall  = 1'b1;
        // A reset cycle never accepts or writes a word
        dbg_ready = !nrst;
        accept    = dbg_valid && !nrst;
        if (accept) begin
          waddr_d   = dbg_addr;
          wdata_d   = dbg_instr;
          mem_waddr = dbg_addr;
          mem_wdata = dbg_instr;
          if (in_range) begin
            mem_we = 1'b1;
            if (load_count_q != {CNT_W{1'b1}}) begin
              load_count_d = load_count_q + CNT_W'(1);
            end
          end else begin
            addr_err_d = 1'b1;
          end
          if (dbg_last || !dbg_req) begin
            state_d = ST_RESTART;
          end
        end else if (!dbg_req) begin
          state_d = ST_RESTART;
        end
      end

      ST_RESTART: begin
        // Single-cycle override: frontend npc forced to 0, core controls ignored
        fe_stall = 1'b0;
        fe_pcsel = PCSEL_ZERO;
        state_d  = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= '0;
      load_count_q <= '0;
      addr_err_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      load_count_q <= load_count_d;
      addr_err_q   <= addr_err_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy       = (state_q != ST_RUN);
  assign load_count = load_count_q;
  assign addr_err   = addr_err_q;

endmodule
